// File: rtl/analyzer_pkg.sv
// ---------------------------------------------------------------------------
// analyzer_pkg
//   Shared types and constants for number_analyzer and every consumer of its
//   results (analyzer_result_collector, result_fifo, host-side readers).
//
//   Contents:
//     FLAG_ODD / FLAG_FIB / FLAG_PAL : bit positions inside a flags vector
//     FLAGS_W                        : width of the flags vector (3)
//     result_t                       : {number[31:0], flags[2:0]}, 35 bits
//     make_result()                  : builds a result_t from raw analyzer bits
// ---------------------------------------------------------------------------
package analyzer_pkg;

  localparam int FLAG_ODD = 0;
  localparam int FLAG_FIB = 1;
  localparam int FLAG_PAL = 2;
  localparam int FLAGS_W  = 3;
  localparam int NUMBER_W = 32;

  typedef struct packed {
    logic [NUMBER_W-1:0] number;
    logic [FLAGS_W-1:0]  flags;   // {pal, fib, odd}
  } result_t;

  // Packs the analyzer outputs so that flags land on their FLAG_* positions.
  function automatic result_t make_result(
    input logic [NUMBER_W-1:0] number,
    input logic                odd,
    input logic                fib,
    input logic                pal
  );
    result_t r;
    r.number          = number;
    r.flags           = '0;
    r.flags[FLAG_ODD] = odd;
    r.flags[FLAG_FIB] = fib;
    r.flags[FLAG_PAL] = pal;
    return r;
  endfunction

endpackage : analyzer_pkg

// File: rtl/result_fifo.sv
// ---------------------------------------------------------------------------
// result_fifo
//   Synchronous single-clock FIFO of analyzer_pkg::result_t entries.
//   The head entry is read combinationally from storage (first-word
//   fall-through), so o_data is valid whenever o_empty is low.
//
//   Parameters:
//     DEPTH   : number of entries, power of two, >= 2
//   Ports:
//     clock   : rising-edge clock
//     reset   : synchronous active-high, empties the FIFO
//     i_push  : write request, i_data is stored when accepted
//     i_data  : entry to store
//     i_pop   : read request, ignored while empty
//     o_data  : head entry (don't-care while empty)
//     o_full  : DEPTH entries held
//     o_empty : no entries held
//
//   A push while full is accepted only when a pop happens in the same cycle;
//   otherwise it is discarded here and the caller accounts for the loss.
// ---------------------------------------------------------------------------
module result_fifo
  import analyzer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    i_push,
  input  result_t i_data,
  input  logic    i_pop,
  output result_t o_data,
  output logic    o_full,
  output logic    o_empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  result_t       r_mem [DEPTH];

  logic          w_do_pop;
  logic          w_do_push;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];

  assign o_empty  = (r_wr_ptr == r_rd_ptr);
  assign o_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  assign w_do_pop  = i_pop & ~o_empty;
  // Full-and-popping frees the slot being written this very edge.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_data = r_mem[w_rd_idx];

  // Storage has no reset: contents are meaningless until the pointers say so.
  always_ff @(posedge clock) begin
    if (w_do_push && !reset) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule : result_fifo

// File: rtl/analyzer_result_collector.sv
// ---------------------------------------------------------------------------
// analyzer_result_collector
//   Captures each completed number_analyzer result (rising edge of all_ready,
//   qualified by enable) into a result_fifo and presents the oldest entry on
//   a valid/ready port. Keeps saturating statistics counters.
//
//   Build option:
//     COLLECTOR_STATS_EN : when defined, the five counters are built; when
//                          undefined, every count_* output is tied to 0.
//
//   Parameters:
//     DEPTH : FIFO entries (power of two, >= 2)
//     CNT_W : width of each statistics counter
//   Ports:
//     clock, reset       : clock and synchronous active-high reset
//     enable             : low = completion events are ignored entirely
//     in_number          : analyzer number
//     all_ready          : analyzer completion level
//     is_odd/is_fib/is_pal : analyzer flags, valid while all_ready is high
//     out_valid/out_ready  : head-of-FIFO handshake
//     out_number/out_flags : head entry, flags = {pal, fib, odd}
//     fifo_full          : FIFO holds DEPTH entries
//     count_total/odd/fib/pal : event statistics (dropped events included)
//     count_drop         : events lost because the FIFO was full
// ---------------------------------------------------------------------------
module analyzer_result_collector
  import analyzer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [31:0]         in_number,
  input  logic                all_ready,
  input  logic                is_odd,
  input  logic                is_fib,
  input  logic                is_pal,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_number,
  output logic [2:0]          out_flags,
  output logic                fifo_full,
  output logic [CNT_W-1:0]    count_total,
  output logic [CNT_W-1:0]    count_odd,
  output logic [CNT_W-1:0]    count_fib,
  output logic [CNT_W-1:0]    count_pal,
  output logic [CNT_W-1:0]    count_drop
);

  localparam int NUM_CNT   = 5;
  localparam int CNT_TOTAL = 0;
  localparam int CNT_ODD   = 1;
  localparam int CNT_FIB   = 2;
  localparam int CNT_PAL   = 3;
  localparam int CNT_DROP  = 4;

  logic    r_ready_q;
  logic    w_event;
  logic    w_pop;
  logic    w_drop;
  logic    w_empty;
  result_t w_wr_data;
  result_t w_head;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ready_q <= 1'b0;
    end else begin
      r_ready_q <= all_ready;
    end
  end

  // A level held high yields a single event; after reset r_ready_q is 0, so
  // an all_ready already high then still counts once.
  assign w_event   = all_ready & ~r_ready_q & enable;
  assign w_pop     = out_valid & out_ready;
  assign w_drop    = w_event & fifo_full & ~w_pop;
  assign w_wr_data = make_result(in_number, is_odd, is_fib, is_pal);

  result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_event),
    .i_data  (w_wr_data),
    .i_pop   (out_ready),
    .o_data  (w_head),
    .o_full  (fifo_full),
    .o_empty (w_empty)
  );

  assign out_valid  = ~w_empty;
  assign out_number = w_head.number;
  assign out_flags  = w_head.flags;

`ifdef COLLECTOR_STATS_EN
  logic [NUM_CNT-1:0] w_cnt_inc;
  logic [CNT_W-1:0]   r_cnt [NUM_CNT];

  always_comb begin
    w_cnt_inc            = '0;
    w_cnt_inc[CNT_TOTAL] = w_event;
    w_cnt_inc[CNT_ODD]   = w_event & is_odd;
    w_cnt_inc[CNT_FIB]   = w_event & is_fib;
    w_cnt_inc[CNT_PAL]   = w_event & is_pal;
    w_cnt_inc[CNT_DROP]  = w_drop;
  end

  // Each counter sticks at all-ones instead of wrapping.
  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    always_ff @(posedge clock) begin
      if (reset) begin
        r_cnt[gi] <= '0;
      end else if (w_cnt_inc[gi] && (r_cnt[gi] != {CNT_W{1'b1}})) begin
        r_cnt[gi] <= r_cnt[gi] + 1'b1;
      end
    end
  end

  assign count_total = r_cnt[CNT_TOTAL];
  assign count_odd   = r_cnt[CNT_ODD];
  assign count_fib   = r_cnt[CNT_FIB];
  assign count_pal   = r_cnt[CNT_PAL];
  assign count_drop  = r_cnt[CNT_DROP];
`else
  // Statistics not built: inputs that only feed counters are intentionally
  // left without a load.
  logic w_stats_unused;
  assign w_stats_unused = ^{w_drop, NUM_CNT[0], CNT_TOTAL[0], CNT_ODD[0],
                            CNT_FIB[0], CNT_PAL[0], CNT_DROP[0]};

  assign count_total = '0;
  assign count_odd   = '0;
  assign count_fib   = '0;
  assign count_pal   = '0;
  assign count_drop  = '0;
`endif

endmodule : analyzer_result_collector

// File: tb/tb_analyzer_result_collector.sv
module tb_analyzer_result_collector;
  import analyzer_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef COLLECTOR_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset, enable, all_ready, is_odd, is_fib, is_pal, out_ready;
  logic [31:0]      in_number;
  logic             out_valid, fifo_full;
  logic [31:0]      out_number;
  logic [2:0]       out_flags;
  logic [CNT_W-1:0] count_total, count_odd, count_fib, count_pal, count_drop;

  analyzer_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .enable(enable), .in_number(in_number),
    .all_ready(all_ready), .is_odd(is_odd), .is_fib(is_fib), .is_pal(is_pal),
    .out_valid(out_valid), .out_ready(out_ready), .out_number(out_number),
    .out_flags(out_flags), .fifo_full(fifo_full), .count_total(count_total),
    .count_odd(count_odd), .count_fib(count_fib), .count_pal(count_pal),
    .count_drop(count_drop)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a queue of results plus plain integer statistics.
  result_t m_q[$];
  bit      m_prev;
  int      m_total, m_odd, m_fib, m_pal, m_drop;
  result_t obs_pops[$];
  logic [31:0] sent[$];

  // Flags computed from first principles: odd, Fibonacci member, decimal palindrome.
  function automatic logic [2:0] ref_flags(input logic [31:0] n);
    longint unsigned a = 0, b = 1, t, x, r;
    bit fib = 0;
    bit pal;
    while (a <= longint'(n)) begin
      if (a == longint'(n)) fib = 1;
      t = a + b; a = b; b = t;
    end
    x = n; r = 0;
    while (x != 0) begin
      r = r * 10 + (x % 10);
      x = x / 10;
    end
    pal = (r == longint'(n));
    return {pal, fib, n[0]};
  endfunction

  function automatic logic [CNT_W-1:0] expc(input int v);
    return STATS_EN ? v[CNT_W-1:0] : '0;
  endfunction

  function automatic int sat(input int v);
    return (v < MAXC) ? v + 1 : v;
  endfunction

  // Advances the model by one clock edge using the inputs currently driven,
  // then lets the DUT take the same edge and settles 1 time unit after it.
  task automatic cycle();
    bit ev, pp;
    if (out_valid && out_ready && !reset)
      obs_pops.push_back('{number: out_number, flags: out_flags});
    if (reset) begin
      m_q.delete();
      m_prev = 0;
      m_total = 0; m_odd = 0; m_fib = 0; m_pal = 0; m_drop = 0;
    end else begin
      ev = all_ready && !m_prev && enable;
      pp = out_ready && (m_q.size() > 0);
      m_prev = all_ready;
      if (pp) void'(m_q.pop_front());
      if (ev) begin
        m_total = sat(m_total);
        if (is_odd) m_odd = sat(m_odd);
        if (is_fib) m_fib = sat(m_fib);
        if (is_pal) m_pal = sat(m_pal);
        if (m_q.size() < DEPTH) m_q.push_back('{number: in_number, flags: {is_pal, is_fib, is_odd}});
        else m_drop = sat(m_drop);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive_number(input logic [31:0] n);
    in_number = n;
    {is_pal, is_fib, is_odd} = ref_flags(n);
  endtask

  task automatic pulse_event(input logic [31:0] n);
    drive_number(n);
    sent.push_back(n);
    all_ready = 1'b1;
    cycle();
    all_ready = 1'b0;
    cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1; all_ready = 1'b0; out_ready = 1'b0; enable = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    obs_pops.delete();
    sent.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    n_checks++; if (fifo_full !== 1'b0) begin n_errors++; $display("FAIL reset_full got %0b want 0", fifo_full); end
    n_checks++; if ({count_total, count_odd, count_fib, count_pal, count_drop} !== '0) begin
      n_errors++; $display("FAIL reset_counters got %0h want 0", {count_total, count_odd, count_fib, count_pal, count_drop});
    end
  endtask

  task automatic test_analyzer_seq();
    logic [31:0] nums [5];
    logic [2:0]  want [5];
    nums = '{32'd1346269, 32'd1187811, 32'd832040, 32'd13469, 32'd1669};
    want = '{3'b011, 3'b101, 3'b010, 3'b001, 3'b001};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) pulse_event(nums[i]);
    cycle();
    n_checks++; if (obs_pops.size() != 5) begin n_errors++; $display("FAIL seq_count got %0d want 5", obs_pops.size()); end
    for (int i = 0; i < 5 && i < obs_pops.size(); i++) begin
      n_checks++; if (obs_pops[i].flags !== want[i]) begin n_errors++; $display("FAIL seq_flags[%0d] got %b want %b", i, obs_pops[i].flags, want[i]); end
      n_checks++; if (obs_pops[i].number !== nums[i]) begin n_errors++; $display("FAIL seq_number[%0d] got %0d want %0d", i, obs_pops[i].number, nums[i]); end
    end
    n_checks++; if (count_total !== expc(5)) begin n_errors++; $display("FAIL seq_total got %0d want %0d", count_total, expc(5)); end
    n_checks++; if (count_odd !== expc(4)) begin n_errors++; $display("FAIL seq_odd got %0d want %0d", count_odd, expc(4)); end
    n_checks++; if (count_fib !== expc(2)) begin n_errors++; $display("FAIL seq_fib got %0d want %0d", count_fib, expc(2)); end
    n_checks++; if (count_pal !== expc(1)) begin n_errors++; $display("FAIL seq_pal got %0d want %0d", count_pal, expc(1)); end
    n_checks++; if (count_drop !== '0) begin n_errors++; $display("FAIL seq_drop got %0d want 0", count_drop); end
  endtask

  task automatic test_level_hold();
    do_reset();
    drive_number(32'd21);
    all_ready = 1'b1;
    for (int i = 0; i < 50; i++) cycle();
    all_ready = 1'b0;
    cycle();
    drive_number(32'd34);
    all_ready = 1'b1;
    cycle();
    all_ready = 1'b0;
    cycle();
    n_checks++; if (count_total !== expc(2)) begin n_errors++; $display("FAIL hold_total got %0d want %0d", count_total, expc(2)); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    out_ready = 1'b0;
    n_checks++; if (obs_pops.size() != 2) begin n_errors++; $display("FAIL hold_entries got %0d want 2", obs_pops.size()); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      pulse_event(32'd1000 + 32'(i));
      if (i == 7) begin
        n_checks++; if (fifo_full !== 1'b1) begin n_errors++; $display("FAIL ovf_full_after_8 got %0b want 1", fifo_full); end
      end
      if (i == 6) begin
        n_checks++; if (fifo_full !== 1'b0) begin n_errors++; $display("FAIL ovf_full_after_7 got %0b want 0", fifo_full); end
      end
    end
    n_checks++; if (count_drop !== expc(2)) begin n_errors++; $display("FAIL ovf_drop got %0d want %0d", count_drop, expc(2)); end
    n_checks++; if (count_total !== expc(10)) begin n_errors++; $display("FAIL ovf_total got %0d want %0d", count_total, expc(10)); end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    out_ready = 1'b0;
    n_checks++; if (obs_pops.size() != 8) begin n_errors++; $display("FAIL ovf_drain_count got %0d want 8", obs_pops.size()); end
    for (int i = 0; i < 8 && i < obs_pops.size(); i++) begin
      n_checks++; if (obs_pops[i].number !== 32'd1000 + 32'(i)) begin
        n_errors++; $display("FAIL ovf_drain[%0d] got %0d want %0d", i, obs_pops[i].number, 1000 + i);
      end
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 8; i++) pulse_event(32'd500 + 32'(i));
    drive_number(32'd777);
    all_ready = 1'b1;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    all_ready = 1'b0;
    n_checks++; if (fifo_full !== 1'b1) begin n_errors++; $display("FAIL fullpop_full got %0b want 1", fifo_full); end
    n_checks++; if (count_drop !== '0) begin n_errors++; $display("FAIL fullpop_drop got %0d want 0", count_drop); end
    n_checks++; if (out_number !== 32'd501) begin n_errors++; $display("FAIL fullpop_head got %0d want 501", out_number); end
    cycle();
    out_ready = 1'b1;
    obs_pops.delete();
    for (int i = 0; i < 9; i++) cycle();
    out_ready = 1'b0;
    n_checks++; if (obs_pops.size() != 8) begin n_errors++; $display("FAIL fullpop_drain_count got %0d want 8", obs_pops.size()); end
    else begin
      n_checks++; if (obs_pops[7].number !== 32'd777) begin n_errors++; $display("FAIL fullpop_last got %0d want 777", obs_pops[7].number); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) pulse_event(32'd55 + 32'(i));
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL rstmid_pre_valid got %0b want 1", out_valid); end
    drive_number(32'd99);
    reset = 1'b1;
    all_ready = 1'b1;
    cycle();
    reset = 1'b0;
    all_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid got %0b want 0", out_valid); end
    n_checks++; if ({count_total, count_odd, count_fib, count_pal, count_drop} !== '0) begin
      n_errors++; $display("FAIL rstmid_counters got %0h want 0", {count_total, count_odd, count_fib, count_pal, count_drop});
    end
    cycle();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_no_capture got %0b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) pulse_event($urandom | 32'd1);
    n_checks++; if (count_odd !== expc(15)) begin n_errors++; $display("FAIL sat_odd got %0d want %0d", count_odd, expc(15)); end
    n_checks++; if (count_total !== expc(15)) begin n_errors++; $display("FAIL sat_total got %0d want %0d", count_total, expc(15)); end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] pool [6];
    pool = '{32'd1346269, 32'd1187811, 32'd832040, 32'd12321, 32'd89, 32'd0};
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) all_ready = ~all_ready;
      enable    = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      reset     = ($urandom_range(0, 299) == 0);
      drive_number(($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 5)] : $urandom);
      cycle();
      n_checks++; if (out_valid !== (m_q.size() != 0)) begin n_errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", c, out_valid, m_q.size() != 0); end
      n_checks++; if (fifo_full !== (m_q.size() == DEPTH)) begin n_errors++; $display("FAIL rnd_full cyc %0d got %0b want %0b", c, fifo_full, m_q.size() == DEPTH); end
      if (m_q.size() != 0) begin
        n_checks++; if ({out_number, out_flags} !== m_q[0]) begin n_errors++; $display("FAIL rnd_head cyc %0d got %0h want %0h", c, {out_number, out_flags}, m_q[0]); end
      end
      n_checks++; if ({count_total, count_odd, count_fib, count_pal, count_drop} !==
                      {expc(m_total), expc(m_odd), expc(m_fib), expc(m_pal), expc(m_drop)}) begin
        n_errors++; $display("FAIL rnd_counters cyc %0d got %0h want %0h", c, {count_total, count_odd, count_fib, count_pal, count_drop},
                             {expc(m_total), expc(m_odd), expc(m_fib), expc(m_pal), expc(m_drop)});
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; all_ready = 1'b0; out_ready = 1'b0;
    in_number = '0; is_odd = 1'b0; is_fib = 1'b0; is_pal = 1'b0;
    m_prev = 0; m_total = 0; m_odd = 0; m_fib = 0; m_pal = 0; m_drop = 0;
    test_reset();
    test_analyzer_seq();
    test_level_hold();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_analyzer_result_collector
